// File: rtl/mult_nibble_seq_pkg.sv
// Shared constants for the sequential nibble multiplier: FSM encodings and nibble width.
package mult_nibble_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NIB_W = 4;

endpackage

// File: rtl/shift_add_mult4.sv
// Combinational 4x4 unsigned shift-add multiplier producing an 8-bit product.
module shift_add_mult4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] prod
);

  // Sum of a shifted by each set bit of b
  always_comb begin
    prod = 8'd0;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) begin
        prod = prod + ({4'd0, a} << k);
      end else begin
        prod = prod;
      end
    end
  end

endmodule

// File: rtl/mult_nibble_seq.sv
// Sequential NxN unsigned multiplier: one nibble-pair multiply-accumulate per cycle,
// with valid/ready handshakes on operands and result.
module mult_nibble_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);
  import mult_nibble_seq_pkg::*;

  localparam int NIB = N / NIB_W;
  localparam int CW  = $clog2(NIB * NIB);
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int SW  = $clog2(2 * N);
  localparam logic [CW-1:0] LAST = CW'(NIB * NIB - 1);

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic [2*N-1:0]   p_r;

  logic [NIB_W-1:0] a_nib_s [NIB];
  logic [NIB_W-1:0] b_nib_s [NIB];
  logic [IW-1:0]    i_s;
  logic [IW-1:0]    j_s;
  logic [IW:0]      ij_s;
  logic [SW-1:0]    shift_s;
  logic [NIB_W-1:0] nib_a_s;
  logic [NIB_W-1:0] nib_b_s;
  logic [7:0]       pp_s;
  logic [2*N-1:0]   pp_ext_s;
  logic             in_ready_s;
  logic             accept_s;

  for (genvar k = 0; k < NIB; k++) begin : g_nib
    assign a_nib_s[k] = a_r[k*NIB_W +: NIB_W];
    assign b_nib_s[k] = b_r[k*NIB_W +: NIB_W];
  end

  // Nibble selection and placement of the partial product at offset 4*(i+j)
  always_comb begin
    i_s      = IW'(cnt_r % CW'(NIB));
    j_s      = IW'(cnt_r / CW'(NIB));
    nib_a_s  = a_nib_s[i_s];
    nib_b_s  = b_nib_s[j_s];
    ij_s     = {1'b0, i_s} + {1'b0, j_s};
    shift_s  = SW'({ij_s, 2'b00});
    pp_ext_s = {{(2*N-8){1'b0}}, pp_s} << shift_s;
  end

  shift_add_mult4 u_mult4 (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .prod (pp_s)
  );

  // Handshake decode; a consumed result frees the slot in the same cycle
  always_comb begin
    in_ready_s = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    accept_s   = in_valid & in_ready_s;
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r == ST_RUN);
  assign p         = p_r;

  // FSM, counter, operand capture and product accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      p_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            p_r     <= '0;
            cnt_r   <= '0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          p_r   <= p_r + pp_ext_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            p_r     <= '0;
            cnt_r   <= '0;
            state_r <= ST_RUN;
          end else if (out_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_nibble_seq.sv
// Randomized self-checking bench for mult_nibble_seq against an arithmetic product model.
module tb_mult_nibble_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  int total;
  int bad;

  mult_nibble_seq #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait (bounded) for in_ready, take the accepting edge
  task automatic start(input logic [15:0] av, input logic [15:0] bv);
    int w;
    a = av;
    b = bv;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // From just after the accepting edge: result must appear on the 16th further edge
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int lat;
    int bcnt;
    lat = 0;
    bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd16);
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd16);
    chk({tag, "_p"}, 64'(p), 64'(exp));
  endtask

  // Hold the result for some cycles, then consume it
  task automatic release_result(input string tag, input logic [31:0] exp, input int stall);
    for (int k = 0; k < stall; k++) begin
      tick();
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_p"}, 64'(p), 64'(exp));
    end
    out_ready = 1'b1;
    #1;
    chk({tag, "_ready_in_done"}, 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b0;
    #1;
    chk({tag, "_valid_cleared"}, 64'(out_valid), 64'd0);
    chk({tag, "_p_retained"}, 64'(p), 64'(exp));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] model;
    int stray;

    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 16'd0;
    b = 16'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_p", 64'(p), 64'd0);

    // Abort mid-run: no result may be emitted afterwards
    start(16'h1234, 16'h5678);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_p", 64'(p), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid || busy) stray++;
    end
    chk("abort_no_result", 64'(stray), 64'd0);
    start(16'd3, 16'd5);
    wait_done("small", 32'h0000000F);
    release_result("small", 32'h0000000F, 1);

    start(16'h1234, 16'h5678);
    wait_done("mixed", 32'h06260060);
    release_result("mixed", 32'h06260060, 0);

    start(16'hFFFF, 16'hFFFF);
    wait_done("max", 32'hFFFE0001);
    release_result("max", 32'hFFFE0001, 0);

    start(16'h0000, 16'hABCD);
    wait_done("zero", 32'h00000000);
    release_result("zero", 32'h00000000, 0);

    // Backpressure with a pending request, then back-to-back hand-over
    start(16'h00FF, 16'h0100);
    wait_done("bp", 32'h0000FF00);
    a = 16'h0002;
    b = 16'h0003;
    in_valid = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!out_valid || p !== 32'h0000FF00 || in_ready || busy) stray++;
    end
    chk("bp_hold", 64'(stray), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_out_valid", 64'(out_valid), 64'd0);
    chk("b2b_p_cleared", 64'(p), 64'd0);
    wait_done("b2b", 32'h00000006);
    release_result("b2b", 32'h00000006, 0);

    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n == 0) ra = 16'hFFFF;
      if (n == 1) rb = 16'h0000;
      model = 32'(longint'(ra) * longint'(rb));
      start(ra, rb);
      wait_done("rand", model);
      release_result("rand", model, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
